// File: rtl/washer_actuator_ctrl_pkg.sv
// Shared stage/agitation encodings and default actuator timing for the washer
// sequencer and the actuator controller.
package washer_actuator_ctrl_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } stage_e;

  typedef enum logic [1:0] {
    AG_FWD = 2'd0,
    AG_P1  = 2'd1,
    AG_REV = 2'd2,
    AG_P2  = 2'd3
  } ag_state_e;

  localparam int DEF_AGIT_ON       = 6;
  localparam int DEF_AGIT_PAUSE    = 2;
  localparam int DEF_RAMP_INTERVAL = 4;
  localparam int DEF_RAMP_STEP     = 32;
  localparam int DEF_UNLOCK_DELAY  = 8;
  localparam int DEF_BUZZ_CYCLES   = 5;
  localparam int DEF_PWM_W         = 8;

  function automatic logic stage_legal(input logic [STAGE_W-1:0] code);
    return (code <= 3'd5);
  endfunction

  // Codes 6/7 are run exactly like IDLE so the actuators fall to a safe state.
  function automatic logic [STAGE_W-1:0] stage_sanitise(input logic [STAGE_W-1:0] code);
    return stage_legal(code) ? code : STAGE_W'(ST_IDLE);
  endfunction

endpackage

// File: rtl/washer_actuator_ctrl_if.sv
// Stage/supply inputs and actuator outputs between the washer sequencer and
// the actuator controller.
interface washer_actuator_ctrl_if;
  import washer_actuator_ctrl_pkg::*;

  logic [STAGE_W-1:0] stage;
  logic               supply;
  logic               valve_on;
  logic               drain_on;
  logic               motor_en;
  logic               motor_dir;
  logic               motor_pwm;
  logic               door_lock;
  logic               buzzer;
  logic               fault;

  modport master (
    output stage, supply,
    input  valve_on, drain_on, motor_en, motor_dir, motor_pwm, door_lock, buzzer, fault
  );

  modport slave (
    input  stage, supply,
    output valve_on, drain_on, motor_en, motor_dir, motor_pwm, door_lock, buzzer, fault
  );

endinterface

// File: rtl/washer_pwm_ramp.sv
// Spin duty ramp with saturation plus free-running PWM counter; exposes the
// comparator result for the state the next clock edge will load.
module washer_pwm_ramp
  import washer_actuator_ctrl_pkg::*;
#(
  parameter int RAMP_INTERVAL = DEF_RAMP_INTERVAL,
  parameter int RAMP_STEP     = DEF_RAMP_STEP,
  parameter int PWM_W         = DEF_PWM_W
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic spin,
  input  logic restart,
  output logic pwm_next
);

  localparam int RC_W = $clog2(RAMP_INTERVAL) + 1;

  logic [PWM_W-1:0] duty_r, duty_nxt_s;
  logic [PWM_W-1:0] cnt_r, cnt_nxt_s;
  logic [RC_W-1:0]  ramp_r, ramp_nxt_s;
  logic [PWM_W:0]   sum_s;

  // next duty/ramp/counter; frozen without mains, cleared outside SPIN
  always_comb begin
    duty_nxt_s = duty_r;
    cnt_nxt_s  = cnt_r;
    ramp_nxt_s = ramp_r;
    sum_s      = {1'b0, duty_r} + (PWM_W+1)'(RAMP_STEP);
    if (!run) begin
      duty_nxt_s = duty_r;
      cnt_nxt_s  = cnt_r;
      ramp_nxt_s = ramp_r;
    end else if (!spin || restart) begin
      duty_nxt_s = PWM_W'(0);
      cnt_nxt_s  = PWM_W'(0);
      ramp_nxt_s = RC_W'(0);
    end else begin
      cnt_nxt_s = cnt_r + PWM_W'(1);
      if (ramp_r == RC_W'(RAMP_INTERVAL - 1)) begin
        ramp_nxt_s = RC_W'(0);
        duty_nxt_s = sum_s[PWM_W] ? {PWM_W{1'b1}} : sum_s[PWM_W-1:0];
      end else begin
        ramp_nxt_s = ramp_r + RC_W'(1);
      end
    end
  end

  assign pwm_next = (cnt_nxt_s < duty_nxt_s);

  // ramp and PWM state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_r <= PWM_W'(0);
      cnt_r  <= PWM_W'(0);
      ramp_r <= RC_W'(0);
    end else begin
      duty_r <= duty_nxt_s;
      cnt_r  <= cnt_nxt_s;
      ramp_r <= ramp_nxt_s;
    end
  end

endmodule

// File: rtl/washer_actuator_ctrl.sv
// Washer actuator controller: turns the sequencer stage code into valve, pump,
// motor, door-lock and buzzer drive, with agitation, spin ramp and hold-offs.
module washer_actuator_ctrl
  import washer_actuator_ctrl_pkg::*;
#(
  parameter int AGIT_ON       = DEF_AGIT_ON,
  parameter int AGIT_PAUSE    = DEF_AGIT_PAUSE,
  parameter int RAMP_INTERVAL = DEF_RAMP_INTERVAL,
  parameter int RAMP_STEP     = DEF_RAMP_STEP,
  parameter int UNLOCK_DELAY  = DEF_UNLOCK_DELAY,
  parameter int BUZZ_CYCLES   = DEF_BUZZ_CYCLES,
  parameter int PWM_W         = DEF_PWM_W
) (
  input  logic                   clk,
  input  logic                   rst,
  washer_actuator_ctrl_if.slave  bus
);

  localparam int AG_MAX = (AGIT_ON > AGIT_PAUSE) ? AGIT_ON : AGIT_PAUSE;
  localparam int AG_CW  = $clog2(AG_MAX) + 1;
  localparam int UL_CW  = $clog2(UNLOCK_DELAY + 1) + 1;
  localparam int BZ_CW  = $clog2(BUZZ_CYCLES + 1) + 1;

  logic [STAGE_W-1:0] stage_q_r, prev_stage_r, eff_s;
  logic               run_s, entry_s, agit_s, spin_s, motor_stage_s;
  ag_state_e          ag_r, ag_nxt_s;
  logic [AG_CW-1:0]   ag_cnt_r, ag_cnt_nxt_s, ag_limit_s;
  logic [UL_CW-1:0]   unlock_cnt_r, unlock_cnt_nxt_s;
  logic [BZ_CW-1:0]   buzz_cnt_r, buzz_cnt_nxt_s;
  logic               fault_r, ramp_pwm_s, pause_last_s;
  logic valve_r, drain_r, motor_en_r, motor_dir_r, motor_pwm_r, door_lock_r, buzzer_r;
  logic valve_nxt_s, drain_nxt_s, en_nxt_s, dir_nxt_s, pwm_nxt_s, lock_nxt_s, buzz_nxt_s;

  assign run_s         = bus.supply;
  assign eff_s         = stage_sanitise(stage_q_r);
  assign entry_s       = (stage_q_r != prev_stage_r);
  assign agit_s        = (eff_s == ST_WASH) || (eff_s == ST_RINSE);
  assign spin_s        = (eff_s == ST_SPIN);
  assign motor_stage_s = agit_s || spin_s;
  assign ag_limit_s    = ((ag_r == AG_FWD) || (ag_r == AG_REV)) ?
                         AG_CW'(AGIT_ON - 1) : AG_CW'(AGIT_PAUSE - 1);

  washer_pwm_ramp #(
    .RAMP_INTERVAL (RAMP_INTERVAL),
    .RAMP_STEP     (RAMP_STEP),
    .PWM_W         (PWM_W)
  ) u_ramp (
    .clk      (clk),
    .rst      (rst),
    .run      (run_s),
    .spin     (spin_s),
    .restart  (entry_s),
    .pwm_next (ramp_pwm_s)
  );

  // agitation next state; a restart while reversing goes via a pause so the
  // direction never flips under power
  always_comb begin
    ag_nxt_s     = ag_r;
    ag_cnt_nxt_s = ag_cnt_r;
    if (agit_s && entry_s) begin
      ag_cnt_nxt_s = AG_CW'(0);
      ag_nxt_s     = (motor_en_r && !motor_dir_r) ? AG_P2 : AG_FWD;
    end else if (agit_s) begin
      if (ag_cnt_r == ag_limit_s) begin
        ag_cnt_nxt_s = AG_CW'(0);
        case (ag_r)
          AG_FWD:  ag_nxt_s = AG_P1;
          AG_P1:   ag_nxt_s = AG_REV;
          AG_REV:  ag_nxt_s = AG_P2;
          AG_P2:   ag_nxt_s = AG_FWD;
          default: ag_nxt_s = AG_FWD;
        endcase
      end else begin
        ag_cnt_nxt_s = ag_cnt_r + AG_CW'(1);
      end
    end else begin
      ag_nxt_s     = ag_r;
      ag_cnt_nxt_s = ag_cnt_r;
    end
  end

  assign pause_last_s = (ag_cnt_nxt_s == AG_CW'(AGIT_PAUSE - 1));

  // actuator, lock hold-off and buzzer next values
  always_comb begin
    valve_nxt_s      = (eff_s == ST_FILL);
    drain_nxt_s      = (eff_s == ST_RINSE) || spin_s;
    en_nxt_s         = 1'b0;
    dir_nxt_s        = 1'b0;
    pwm_nxt_s        = 1'b0;
    lock_nxt_s       = 1'b0;
    unlock_cnt_nxt_s = UL_CW'(0);
    buzz_nxt_s       = 1'b0;
    buzz_cnt_nxt_s   = BZ_CW'(0);
    if (agit_s) begin
      en_nxt_s  = (ag_nxt_s == AG_FWD) || (ag_nxt_s == AG_REV);
      pwm_nxt_s = 1'b1;
      case (ag_nxt_s)
        AG_FWD:  dir_nxt_s = 1'b1;
        AG_REV:  dir_nxt_s = 1'b0;
        AG_P1:   dir_nxt_s = !pause_last_s;
        AG_P2:   dir_nxt_s = pause_last_s;
        default: dir_nxt_s = 1'b0;
      endcase
    end else if (spin_s) begin
      en_nxt_s  = 1'b1;
      dir_nxt_s = 1'b1;
      pwm_nxt_s = ramp_pwm_s;
    end else begin
      en_nxt_s  = 1'b0;
      dir_nxt_s = 1'b0;
      pwm_nxt_s = 1'b0;
    end
    if (eff_s == ST_FILL) begin
      lock_nxt_s       = 1'b1;
      unlock_cnt_nxt_s = UL_CW'(0);
    end else if (motor_stage_s) begin
      lock_nxt_s       = 1'b1;
      unlock_cnt_nxt_s = UL_CW'(UNLOCK_DELAY);
    end else if (unlock_cnt_r != UL_CW'(0)) begin
      lock_nxt_s       = 1'b1;
      unlock_cnt_nxt_s = unlock_cnt_r - UL_CW'(1);
    end else begin
      lock_nxt_s       = 1'b0;
      unlock_cnt_nxt_s = UL_CW'(0);
    end
    if ((eff_s == ST_DONE) && entry_s) begin
      buzz_nxt_s     = 1'b1;
      buzz_cnt_nxt_s = BZ_CW'(BUZZ_CYCLES - 1);
    end else if (buzz_cnt_r != BZ_CW'(0)) begin
      buzz_nxt_s     = 1'b1;
      buzz_cnt_nxt_s = buzz_cnt_r - BZ_CW'(1);
    end else begin
      buzz_nxt_s     = 1'b0;
      buzz_cnt_nxt_s = BZ_CW'(0);
    end
  end

  // stage capture, agitation FSM and timers; all frozen while mains is absent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q_r    <= STAGE_W'(0);
      prev_stage_r <= STAGE_W'(0);
      ag_r         <= AG_FWD;
      ag_cnt_r     <= AG_CW'(0);
      unlock_cnt_r <= UL_CW'(0);
      buzz_cnt_r   <= BZ_CW'(0);
      fault_r      <= 1'b0;
    end else begin
      fault_r <= fault_r | ~stage_legal(stage_q_r);
      if (run_s) begin
        stage_q_r    <= bus.stage;
        prev_stage_r <= stage_q_r;
        ag_r         <= ag_nxt_s;
        ag_cnt_r     <= ag_cnt_nxt_s;
        unlock_cnt_r <= unlock_cnt_nxt_s;
        buzz_cnt_r   <= buzz_cnt_nxt_s;
      end else begin
        stage_q_r    <= stage_q_r;
        prev_stage_r <= prev_stage_r;
        ag_r         <= ag_r;
        ag_cnt_r     <= ag_cnt_r;
        unlock_cnt_r <= unlock_cnt_r;
        buzz_cnt_r   <= buzz_cnt_r;
      end
    end
  end

  // actuator output registers; power loss kills drives but holds lock and direction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valve_r     <= 1'b0;
      drain_r     <= 1'b0;
      motor_en_r  <= 1'b0;
      motor_dir_r <= 1'b0;
      motor_pwm_r <= 1'b0;
      door_lock_r <= 1'b0;
      buzzer_r    <= 1'b0;
    end else if (run_s) begin
      valve_r     <= valve_nxt_s;
      drain_r     <= drain_nxt_s;
      motor_en_r  <= en_nxt_s;
      motor_dir_r <= dir_nxt_s;
      motor_pwm_r <= pwm_nxt_s;
      door_lock_r <= lock_nxt_s;
      buzzer_r    <= buzz_nxt_s;
    end else begin
      valve_r     <= 1'b0;
      drain_r     <= 1'b0;
      motor_en_r  <= 1'b0;
      motor_dir_r <= motor_dir_r;
      motor_pwm_r <= 1'b0;
      door_lock_r <= door_lock_r;
      buzzer_r    <= 1'b0;
    end
  end

  assign bus.valve_on  = valve_r;
  assign bus.drain_on  = drain_r;
  assign bus.motor_en  = motor_en_r;
  assign bus.motor_dir = motor_dir_r;
  assign bus.motor_pwm = motor_pwm_r;
  assign bus.door_lock = door_lock_r;
  assign bus.buzzer    = buzzer_r;
  assign bus.fault     = fault_r;

endmodule
